// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR sequencer: width, FSM states and the
// feedback function used by the datapath.
package lfsr_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Right shift with feedback into bit3; any nonzero state has period 15.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[1], s[3], s[2], s[1]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 4-bit LFSR register: load a seed, step once when enabled, otherwise hold.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  // Load has priority over step; the two are never requested together by the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for the LFSR: accepts start/seed/count, streams one LFSR value
// per accepted beat, and reports done, seed error and period wrap-around.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic [LFSR_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrap
);

  state_t            state_reg;
  state_t            state_next;
  logic [LFSR_W-1:0] seed_q;
  logic [CNT_W-1:0]  remaining;
  logic              err_flag_reg;
  logic              wrap_reg;
  logic [LFSR_W-1:0] lfsr_val;
  logic              accept;
  logic              handshake;

  // start is only honoured from IDLE; a beat is taken only while streaming.
  assign accept    = (state_reg == IDLE) && start;
  assign handshake = (state_reg == RUN) && out_ready;

  lfsr_core u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (state_reg == LOAD),
    .step  (handshake),
    .seed  (seed_q),
    .value (lfsr_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore outputs; abort beats the last-beat exit to DONE.
  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (seed == '0 || count == '0) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = abort ? IDLE : RUN;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (handshake && remaining == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        err        = err_flag_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run parameters are captured on an accepted start; each beat consumes one count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q       <= '0;
      remaining    <= '0;
      err_flag_reg <= 1'b0;
    end else if (accept) begin
      seed_q       <= seed;
      remaining    <= count;
      err_flag_reg <= (seed == '0);
    end else if (handshake) begin
      remaining    <= remaining - CNT_W'(1);
    end
  end

  // Wrap flags the cycle after a step lands back on the run's seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= handshake && (lfsr_next(lfsr_val) == seed_q);
    end
  end

  assign wrap     = wrap_reg;
  assign out_data = lfsr_val;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: directed runs from the sequence tables
// plus randomized runs predicted by an arithmetic reference model.
module tb_lfsr_seq_ctrl;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [3:0] data;
    logic       wrap_after;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       seed_in;
  logic [CNT_W-1:0] cnt_in;
  logic             abort;
  logic [3:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic             wrap;

  int    n_cmp = 0;
  int    n_err = 0;
  int    run_id = 0;
  beat_t beat_q[$];
  bit    done_q[$];
  int    exp_tab[$];

  lfsr_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed_in),
    .count     (cnt_in),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp = n_cmp + 1;
    n_err = n_err + 1;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Reference step from the feedback rule: shift right, bit3 = s0 xor s1.
  function automatic logic [3:0] ref_step(input logic [3:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = (v ^ (v >> 1)) & 1;
    return 4'((v >> 1) | (fb << 3));
  endfunction

  // Model: beat i is seed stepped i times; a wrap follows every 15th handshake.
  task automatic model_push(input logic [3:0] s, input int c, input bit killed);
    beat_t      e;
    logic [3:0] cur;
    if (s != 4'h0) begin
      cur = s;
      for (int i = 0; i < c; i++) begin
        e.data       = cur;
        e.wrap_after = ((i + 1) % 15 == 0);
        beat_q.push_back(e);
        cur = ref_step(cur);
      end
    end
    if (!killed) done_q.push_back(s == 4'h0 && c != 0 ? 1'b1 : (s == 4'h0));
  endtask

  // Push exp_tab as expected beats, with a wrap after index wrap_idx (-1 = none).
  task automatic push_tab(input int wrap_idx, input bit err_exp);
    beat_t e;
    for (int i = 0; i < exp_tab.size(); i++) begin
      e.data       = 4'(exp_tab[i]);
      e.wrap_after = (i == wrap_idx);
      beat_q.push_back(e);
    end
    done_q.push_back(err_exp);
  endtask

  // One run. ready_mode: 0 always, 1 random, 2 table. kill: 0 none, 1 abort, 2 reset.
  task automatic do_run(input logic [3:0] s, input int c, input int ready_mode,
                        input int kill, input int kill_after);
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int hs = 0;
    int cyc = 0;
    int last_hs = 0;
    bit fin = 0;
    @(posedge clk); #1;
    start = 1'b1; seed_in = s; cnt_in = CNT_W'(c); abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0; seed_in = 4'($urandom); cnt_in = CNT_W'($urandom);
    @(negedge clk);
    if (s == 4'h0 || c == 0) begin
      check("zero_done", done, 1);
      fin = 1;
    end else begin
      check("load_busy", busy, 1);
      check("load_valid", out_valid, 0);
    end
    while (!fin) begin
      @(posedge clk); #1;
      if (kill == 1 && hs == kill_after) begin
        abort = 1'b1; out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b0;
        beat_q.delete();
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        fin = 1;
      end else if (kill == 2 && hs == kill_after) begin
        start = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        beat_q.delete();
        done_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        fin = 1;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 9) < 7);
          default: out_ready = (cyc < 7) ? (pat[cyc] != 0) : 1'b1;
        endcase
        // Starts issued while busy must have no effect.
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; seed_in = 4'($urandom); cnt_in = CNT_W'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        if (cyc == 0) check("first_valid", out_valid, 1);
        if (out_valid && out_ready) begin
          hs = hs + 1;
          last_hs = cyc;
        end
        if (done) begin
          check("done_latency", cyc - last_hs, 1);
          check("handshakes", hs, c);
          fin = 1;
        end
        cyc = cyc + 1;
        if (!fin && cyc > 2000) begin
          fail("run_timeout");
          fin = 1;
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    $display("run %0d: seed=%h count=%0d ready_mode=%0d kill=%0d handshakes=%0d",
             run_id, s, c, ready_mode, kill, hs);
    run_id = run_id + 1;
  endtask

  // Monitor: compares every accepted beat, stall stability, wrap and done/err pulses.
  initial begin
    bit         pend_wrap = 0;
    bit         prev_stall = 0;
    logic [3:0] prev_data = '0;
    beat_t      e;
    bit         e_err;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend_wrap  = 0;
        prev_stall = 0;
      end else begin
        check("wrap", wrap, pend_wrap);
        pend_wrap = 0;
        if (out_valid && prev_stall) check("stall_hold", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (beat_q.size() == 0) begin
            fail("unexpected_beat");
          end else begin
            e = beat_q.pop_front();
            check("beat", out_data, e.data);
            pend_wrap = e.wrap_after;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (done) begin
          if (done_q.size() == 0) begin
            fail("unexpected_done");
          end else begin
            e_err = done_q.pop_front();
            check("err", err, e_err);
          end
        end else begin
          check("err_idle", err, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rs;
    int         rc;
    int         rm;
    int         rk;
    int         ra;
    rst = 1'b0; start = 1'b0; seed_in = '0; cnt_in = '0; abort = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_data", out_data, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_wrap", wrap, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Short run, full throughput.
    exp_tab = '{1, 8, 4, 2, 9};
    push_tab(-1, 1'b0);
    do_run(4'h1, 5, 0, 0, 0);

    // Full period plus one: single wrap after the 15th beat.
    exp_tab = '{1, 8, 4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3, 1};
    push_tab(14, 1'b0);
    do_run(4'h1, 16, 0, 0, 0);

    // Zero seed: immediate done with err, no beats.
    exp_tab = {};
    push_tab(-1, 1'b1);
    do_run(4'h0, 7, 0, 0, 0);

    // Zero count with a valid seed: done without err.
    exp_tab = {};
    push_tab(-1, 1'b0);
    do_run(4'h9, 0, 0, 0, 0);

    // Backpressure pattern.
    exp_tab = '{10, 13, 14, 15};
    push_tab(-1, 1'b0);
    do_run(4'hA, 4, 2, 0, 0);

    // Abort after the third beat, then a fresh run.
    model_push(4'h1, 10, 1'b1);
    do_run(4'h1, 10, 0, 1, 3);
    exp_tab = '{2, 9, 12};
    push_tab(-1, 1'b0);
    do_run(4'h2, 3, 0, 0, 0);

    // Asynchronous reset mid-run, then a clean run.
    model_push(4'h5, 20, 1'b1);
    do_run(4'h5, 20, 0, 2, 4);
    exp_tab = '{3, 1};
    push_tab(-1, 1'b0);
    do_run(4'h3, 2, 0, 0, 0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      rs = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rc = $urandom_range(0, 40);
      rm = $urandom_range(0, 1);
      rk = 0;
      ra = 0;
      if (rs != 4'h0 && rc >= 2 && $urandom_range(0, 4) == 0) begin
        rk = 1;
        ra = $urandom_range(1, rc - 1);
      end
      model_push(rs, rc, rk != 0);
      do_run(rs, rc, rm, rk, ra);
    end

    repeat (3) @(posedge clk);
    if (beat_q.size() != 0) fail("beats_left");
    if (done_q.size() != 0) fail("dones_left");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
